// File: rtl/xswitch_out_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | xswitch_out_arbiter                                                      |
// | Per-output round-robin arbiter driving the xswitch crossbar selects.     |
// | Optional grant timeout enabled by defining ARB_TIMEOUT_EN.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module xswitch_out_arbiter #(
  parameter int N_PORTS     = 4,
  parameter int AW          = $clog2(N_PORTS),
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_PORTS-1:0]    valid_in,
  input  logic [N_PORTS*AW-1:0] addr_in,
  input  logic [N_PORTS-1:0]    rcv_rdy,
  input  logic [N_PORTS-1:0]    data_rd,
  output logic [N_PORTS-1:0]    ack_in,
  output logic [N_PORTS-1:0]    valid_out,
  output logic [N_PORTS*AW-1:0] sel_out,
  output logic [N_PORTS-1:0]    to_err
);

  localparam logic [0:0] c_idle  = 1'b0;
  localparam logic [0:0] c_grant = 1'b1;

  logic [N_PORTS-1:0]    r_ack_in;
  logic [N_PORTS-1:0]    w_ack_nxt;
  logic [N_PORTS-1:0]    w_ack_req;
  logic [N_PORTS-1:0]    w_granted;
  logic [N_PORTS-1:0]    w_busy;
  logic [N_PORTS*AW-1:0] w_sel;

  // Inputs already holding a grant anywhere are kept out of every search,
  // so a mid-grant address change can never produce a second grant.
  always_comb begin
    w_busy = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      if (w_granted[j]) begin
        w_busy[w_sel[j*AW +: AW]] = 1'b1;
      end
    end
  end

  always_comb begin
    w_ack_nxt = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      if (w_ack_req[j]) begin
        w_ack_nxt[w_sel[j*AW +: AW]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack_in <= '0;
    end else begin
      r_ack_in <= w_ack_nxt;
    end
  end

  assign ack_in  = r_ack_in;
  assign sel_out = w_sel;

  for (genvar j = 0; j < N_PORTS; j++) begin : g_out
    logic [0:0]         r_state;
    logic [AW-1:0]      r_ptr;
    logic [AW-1:0]      r_sel;
    logic               r_valid;
    logic [N_PORTS-1:0] w_req;
    logic [AW-1:0]      w_winner;
    logic               w_found;
    logic               w_in_grant;
    logic               w_rel_rd;
    logic               w_rel_wd;
    logic               w_rel_to;

    always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
        w_req[i] = valid_in[i] && (addr_in[i*AW +: AW] == AW'(j)) &&
                   !r_ack_in[i] && !w_busy[i];
      end
    end

    // Search starts at r_ptr; AW-bit wrap gives the mod N_PORTS step.
    always_comb begin
      logic [AW-1:0] idx;
      w_found  = 1'b0;
      w_winner = '0;
      idx      = '0;
      for (int k = 0; k < N_PORTS; k++) begin
        idx = r_ptr + AW'(k);
        if (!w_found && w_req[idx]) begin
          w_found  = 1'b1;
          w_winner = idx;
        end
      end
    end

    assign w_in_grant = (r_state == c_grant);
    assign w_rel_rd   = w_in_grant && data_rd[j];
    assign w_rel_wd   = w_in_grant && !data_rd[j] && !valid_in[r_sel];

`ifdef ARB_TIMEOUT_EN
    localparam int c_cw = $clog2(TIMEOUT_CYC + 1);

    logic [c_cw-1:0] r_cnt;
    logic            r_to_err;

    assign w_rel_to = w_in_grant && !data_rd[j] && valid_in[r_sel] &&
                      (r_cnt == c_cw'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt    <= '0;
        r_to_err <= 1'b0;
      end else begin
        r_to_err <= w_rel_to;
        if (!w_in_grant) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign to_err[j] = r_to_err;
`else
    assign w_rel_to  = 1'b0;
    assign to_err[j] = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state <= c_idle;
        r_ptr   <= '0;
        r_sel   <= '0;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          c_idle: begin
            if (w_found && rcv_rdy[j]) begin
              r_state <= c_grant;
              r_sel   <= w_winner;
              r_valid <= 1'b1;
            end
          end
          default: begin
            if (w_rel_rd || w_rel_to) begin
              r_state <= c_idle;
              r_valid <= 1'b0;
              r_ptr   <= r_sel + AW'(1);
            end else if (w_rel_wd) begin
              r_state <= c_idle;
              r_valid <= 1'b0;
            end
          end
        endcase
      end
    end

    assign valid_out[j]         = r_valid;
    assign w_sel[j*AW +: AW]    = r_sel;
    assign w_granted[j]         = w_in_grant;
    assign w_ack_req[j]         = w_rel_rd;
  end

endmodule
`default_nettype wire

// File: tb/tb_xswitch_out_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_xswitch_out_arbiter                                                   |
// | Self-checking bench: vector table plus scoreboarded grant/ack sequences. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_xswitch_out_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] valid_in;
  logic [7:0] addr_in;
  logic [3:0] rcv_rdy;
  logic [3:0] data_rd;
  logic [3:0] ack_in;
  logic [3:0] valid_out;
  logic [7:0] sel_out;
  logic [3:0] to_err;

  xswitch_out_arbiter #(.N_PORTS(4), .AW(2), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .addr_in(addr_in),
    .rcv_rdy(rcv_rdy), .data_rd(data_rd), .ack_in(ack_in),
    .valid_out(valid_out), .sel_out(sel_out), .to_err(to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int out; int sel; } grant_t;
  typedef struct {
    logic [3:0] v; logic [7:0] a; logic [3:0] r; logic [3:0] evo; logic [7:0] esel;
  } vec_t;

  grant_t     exp_q[$];
  int         ack_q[$];
  logic [3:0] prev_vo;
  int         checks;
  int         errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    grant_t g;
    int     a;
    for (int j = 0; j < 4; j++) begin
      if (valid_out[j] && !prev_vo[j]) begin
        if (exp_q.size() == 0) begin
          chk("spurious_grant_out", j, 32'hFFFF);
        end else begin
          g = exp_q.pop_front();
          chk("sb_grant_out", j, g.out);
          chk("sb_grant_sel", {30'd0, sel_out[j*2 +: 2]}, g.sel);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (ack_in[i]) begin
        if (ack_q.size() == 0) begin
          chk("spurious_ack_in", i, 32'hFFFF);
        end else begin
          a = ack_q.pop_front();
          chk("sb_ack_in", i, a);
        end
      end
    end
    prev_vo = valid_out;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    monitor();
  endtask

  vec_t tbl[9];

  initial begin
    logic [7:0] mask;
    int         grants;
    int         last;
    int         lat;
    checks = 0; errors = 0; prev_vo = '0;
    reset = 1'b0; valid_in = '0; addr_in = '0; rcv_rdy = 4'hF; data_rd = '0;

    //            valid    addr     rdy     exp vo   exp sel
    tbl[0] = '{4'b0001, 8'h01, 4'b1111, 4'b0010, 8'h00};
    tbl[1] = '{4'b1111, 8'h00, 4'b1111, 4'b0001, 8'h00};
    tbl[2] = '{4'b1110, 8'hAA, 4'b1111, 4'b0100, 8'h10};
    tbl[3] = '{4'b1111, 8'h1B, 4'b1111, 4'b1111, 8'h1B};
    tbl[4] = '{4'b1111, 8'h1B, 4'b0101, 4'b0101, 8'h13};
    tbl[5] = '{4'b1100, 8'hF0, 4'b1111, 4'b1000, 8'h80};
    tbl[6] = '{4'b0000, 8'hFF, 4'b1111, 4'b0000, 8'h00};
    tbl[7] = '{4'b1010, 8'h00, 4'b1110, 4'b0000, 8'h00};
    tbl[8] = '{4'b0110, 8'h14, 4'b1111, 4'b0010, 8'h04};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_sel_out", sel_out, 0);
    chk("rst_ack_in", ack_in, 0);
    chk("rst_to_err", to_err, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Vector table: one-cycle request then withdraw, so pointers stay at 0.
    for (int k = 0; k < 9; k++) begin
      valid_in = tbl[k].v; addr_in = tbl[k].a; rcv_rdy = tbl[k].r;
      mask = '0;
      for (int j = 0; j < 4; j++) begin
        if (tbl[k].evo[j]) begin
          exp_q.push_back('{j, int'(tbl[k].esel[j*2 +: 2])});
          mask[j*2 +: 2] = 2'b11;
        end
      end
      step();
      chk("vec_valid_out", valid_out, tbl[k].evo);
      chk("vec_sel_out", sel_out & mask, tbl[k].esel);
      valid_in = '0;
      step();
      chk("vec_release", valid_out, 0);
      chk("vec_no_ack", ack_in, 0);
    end
    rcv_rdy = 4'hF;

    // in0 -> out1, read three cycles after valid_out
    valid_in = 4'b0001; addr_in = 8'h01;
    exp_q.push_back('{1, 0});
    lat = 0;
    for (int c = 0; c < 8 && !valid_out[1]; c++) begin
      step();
      lat++;
    end
    chk("t2_latency", lat, 1);
    step();
    step();
    chk("t2_held", valid_out, 4'b0010);
    data_rd = 4'b0010;
    ack_q.push_back(0);
    step();
    chk("t2_ack", ack_in, 4'b0001);
    chk("t2_release", valid_out, 0);
    data_rd = '0; valid_in = '0;
    step();
    chk("t2_ack_pulse", ack_in, 0);

    // all inputs -> out3, immediate reads, round-robin 0,1,2,3,0
    valid_in = 4'b1111; addr_in = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{3, i % 4});
      ack_q.push_back(i % 4);
    end
    grants = 0; last = -1;
    for (int c = 0; c < 40 && grants < 5; c++) begin
      step();
      if (valid_out[3]) begin
        if (last >= 0) chk("t3_gap", c - last, 2);
        last = c;
        grants++;
        data_rd = 4'b1000;
        if (grants == 5) valid_in = 4'b0001;
      end else begin
        data_rd = '0;
      end
    end
    chk("t3_grants", grants, 5);
    step();
    valid_in = '0; data_rd = '0;
    step();
    chk("t3_idle", valid_out, 0);

    // in2 -> out0 with receiver not ready for five cycles
    valid_in = 4'b0100; addr_in = 8'h00; rcv_rdy = 4'b1110;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t4_wait_rdy", valid_out[0], 0);
    end
    rcv_rdy = 4'hF;
    exp_q.push_back('{0, 2});
    step();
    chk("t4_grant", valid_out[0], 1);
    chk("t4_sel", sel_out[1:0], 2);
    rcv_rdy = 4'b1110;
    step();
    step();
    chk("t4_rdy_low_held", valid_out[0], 1);
    data_rd = 4'b0001;
    ack_q.push_back(2);
    step();
    chk("t4_ack", ack_in, 4'b0100);
    valid_in = '0; data_rd = '0; rcv_rdy = 4'hF;
    step();

    // in1 -> out2 withdrawn; pointer must stay so in1 beats in3 next
    valid_in = 4'b0010; addr_in = 8'h08;
    exp_q.push_back('{2, 1});
    step();
    chk("t5_grant", valid_out[2], 1);
    valid_in = '0;
    step();
    chk("t5_withdraw", valid_out[2], 0);
    chk("t5_no_ack", ack_in, 0);
    valid_in = 4'b1010; addr_in = 8'h88;
    exp_q.push_back('{2, 1});
    step();
    chk("t5_ptr_kept", sel_out[5:4], 1);
    data_rd = 4'b0100;
    ack_q.push_back(1);
    exp_q.push_back('{2, 3});
    step();
    chk("t5_ack", ack_in, 4'b0010);
    valid_in = 4'b1000; data_rd = '0;
    step();
    chk("t5_rr_next", sel_out[5:4], 3);
    data_rd = 4'b0100;
    ack_q.push_back(3);
    step();
    valid_in = '0; data_rd = '0;
    step();

    // in3 -> out1 held without any read
    valid_in = 4'b1000; addr_in = 8'h40;
    exp_q.push_back('{1, 3});
    step();
    chk("t6_grant", valid_out[1], 1);
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 15; c++) begin
      step();
      chk("t6_hold", valid_out[1], 1);
      chk("t6_no_err", to_err, 0);
    end
    step();
    chk("t6_timeout_release", valid_out[1], 0);
    chk("t6_to_err", to_err, 4'b0010);
    chk("t6_no_ack", ack_in, 0);
    valid_in = '0;
    step();
    chk("t6_err_pulse", to_err, 0);
`else
    for (int c = 0; c < 110; c++) begin
      step();
      chk("t6_hold", valid_out[1], 1);
      chk("t6_no_err", to_err, 0);
    end
    valid_in = '0;
    step();
    chk("t6_withdraw", valid_out[1], 0);
`endif
    step();

    // asynchronous reset while out2 holds a grant
    valid_in = 4'b0001; addr_in = 8'h02;
    exp_q.push_back('{2, 0});
    step();
    chk("t1_grant", valid_out[2], 1);
    chk("t1_sel", sel_out[5:4], 0);
    #2;
    reset = 1'b0;
    #1;
    chk("t1_async_valid", valid_out, 0);
    chk("t1_async_sel", sel_out, 0);
    chk("t1_async_ack", ack_in, 0);
    valid_in = '0;
    prev_vo = '0;
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("t1_after_reset", valid_out, 0);

    chk("sb_grants_drained", exp_q.size(), 0);
    chk("sb_acks_drained", ack_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
